// File: rtl/hilo_pkg.sv
// hilo_pkg: shared types and constants for the HI/LO multiply controller.
// Contents: hilo_state_t FSM encoding, WIDTH_DEF data width, MULT_LATENCY
// (cycles from start to first completed level, used by benches only).
package hilo_pkg;
  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} hilo_state_t;
  localparam int WIDTH_DEF = 32;
  localparam int MULT_LATENCY = 33;
endpackage

// File: rtl/hilo_if.sv
// hilo_if: handshake between hilo_ctrl and the multi-cycle multiplier.
// master (controller): drives MultStart/MultStartSgn, receives mult_hi/mult_lo/mult_done.
// slave (multiplier): the mirror image.
interface hilo_if #(parameter int WIDTH = 32);
  logic MultStart;
  logic MultStartSgn;
  logic [WIDTH-1:0] mult_hi;
  logic [WIDTH-1:0] mult_lo;
  logic mult_done;
  modport master (output MultStart, MultStartSgn, input mult_hi, mult_lo, mult_done);
  modport slave (input MultStart, MultStartSgn, output mult_hi, mult_lo, mult_done);
endinterface

// File: rtl/hilo_regfile.sv
// hilo_regfile: architectural HI/LO registers with write muxing and read mux.
// Ports: clk, rst; cap_i/cap_hi_i/cap_lo_i multiplier capture; wr_hi_i/wr_lo_i/wdata_i
// mthi/mtlo writes; rd_hi_i/rd_lo_i read strobes; byp_i reads the capture values
// instead of the registers; rdata_o read result (0 when no strobe).
module hilo_regfile #(parameter int WIDTH = 32) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cap_i,
  input  logic [WIDTH-1:0] cap_hi_i,
  input  logic [WIDTH-1:0] cap_lo_i,
  input  logic             wr_hi_i,
  input  logic             wr_lo_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             rd_hi_i,
  input  logic             rd_lo_i,
  input  logic             byp_i,
  output logic [WIDTH-1:0] rdata_o
);
  logic [WIDTH-1:0] hi_q, lo_q, hi_d, lo_d, hi_rd, lo_rd;
  always_comb begin
    hi_d = cap_i ? cap_hi_i : wr_hi_i ? wdata_i : hi_q;
    lo_d = cap_i ? cap_lo_i : wr_lo_i ? wdata_i : lo_q;
    hi_rd = byp_i ? cap_hi_i : hi_q;
    lo_rd = byp_i ? cap_lo_i : lo_q;
    rdata_o = rd_hi_i ? hi_rd : rd_lo_i ? lo_rd : '0;
  end
  always_ff @(posedge clk) begin
    hi_q <= rst ? '0 : hi_d;
    lo_q <= rst ? '0 : lo_d;
  end
endmodule

// File: rtl/hilo_ctrl.sv
// hilo_ctrl: execute-stage controller for the multiplier and HI/LO registers.
// Ports: clk, rst; MultE/MultSgnE/MfhiE/MfloE/MthiE/MtloE decoded strobes; SrcAE
// mthi/mtlo data; mif multiplier handshake (master); HiLoOutE mfhi/mflo result;
// StallHL hold F/D/E; Busy multiply in flight.
// Option: HILO_BYPASS_EN forwards mult_hi/mult_lo to mfhi/mflo in the completion cycle.
module hilo_ctrl import hilo_pkg::*; #(parameter int WIDTH = WIDTH_DEF) (
  input  logic             clk,
  input  logic             rst,
  input  logic             MultE,
  input  logic             MultSgnE,
  input  logic             MfhiE,
  input  logic             MfloE,
  input  logic             MthiE,
  input  logic             MtloE,
  input  logic [WIDTH-1:0] SrcAE,
  hilo_if.master           mif,
  output logic [WIDTH-1:0] HiLoOutE,
  output logic             StallHL,
  output logic             Busy
);
  hilo_state_t state_q;
  logic cap, byp, stall_rd, wr_ok;
  always_comb begin
    Busy = state_q == WAIT;
    mif.MultStart = MultE & ~Busy;
    mif.MultStartSgn = MultSgnE & mif.MultStart;
    // done is only meaningful in WAIT; the level left from an earlier multiply is cleared by the start edge
    cap = Busy & mif.mult_done;
`ifdef HILO_BYPASS_EN
    byp = cap;
    stall_rd = (MfhiE | MfloE) & ~cap;
`else
    byp = 1'b0;
    stall_rd = MfhiE | MfloE;
`endif
    StallHL = Busy & (MultE | MthiE | MtloE | stall_rd);
    // a move paired with a multiply is illegal; the multiply wins
    wr_ok = ~StallHL & ~MultE;
  end
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else state_q <= Busy ? (mif.mult_done ? IDLE : WAIT) : (mif.MultStart ? WAIT : IDLE);
  end
  hilo_regfile #(.WIDTH(WIDTH)) u_rf (
    .clk(clk),
    .rst(rst),
    .cap_i(cap),
    .cap_hi_i(mif.mult_hi),
    .cap_lo_i(mif.mult_lo),
    .wr_hi_i(MthiE & wr_ok),
    .wr_lo_i(MtloE & wr_ok),
    .wdata_i(SrcAE),
    .rd_hi_i(MfhiE),
    .rd_lo_i(MfloE),
    .byp_i(byp),
    .rdata_o(HiLoOutE)
  );
endmodule

// File: tb/tb_hilo_ctrl.sv
// tb_hilo_ctrl: scoreboard bench for hilo_ctrl with a behavioural 33-cycle multiplier.
module tb_hilo_ctrl;
  import hilo_pkg::*;
  logic clk = 0, rst = 1;
  logic MultE = 0, MultSgnE = 0, MfhiE = 0, MfloE = 0, MthiE = 0, MtloE = 0;
  logic [31:0] SrcAE = 0, HiLoOutE;
  logic StallHL, Busy;
  logic [31:0] op_a = 0, op_b = 0, a_l = 0, b_l = 0;
  logic sgn_l = 0;
  int cnt = 0;
  int n_cmp = 0, n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] e;
`ifdef HILO_BYPASS_EN
  localparam int EXP_STALL = MULT_LATENCY - 1;
`else
  localparam int EXP_STALL = MULT_LATENCY;
`endif
  hilo_if #(.WIDTH(32)) mif ();
  hilo_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .MultE(MultE), .MultSgnE(MultSgnE), .MfhiE(MfhiE), .MfloE(MfloE),
    .MthiE(MthiE), .MtloE(MtloE), .SrcAE(SrcAE), .mif(mif), .HiLoOutE(HiLoOutE),
    .StallHL(StallHL), .Busy(Busy)
  );
  always #5 clk = ~clk;
  initial begin
    mif.mult_done = 0;
    mif.mult_hi = 0;
    mif.mult_lo = 0;
  end
  // Multiplier model ignores rst so that a stale completion after reset is visible to the DUT.
  always @(posedge clk) begin
    if (mif.MultStart) begin
      cnt <= MULT_LATENCY - 1;
      mif.mult_done <= 0;
      a_l <= op_a;
      b_l <= op_b;
      sgn_l <= mif.MultStartSgn;
    end else if (cnt != 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) begin
        mif.mult_done <= 1;
        {mif.mult_hi, mif.mult_lo} <= sgn_l ? {{32{a_l[31]}}, a_l} * {{32{b_l[31]}}, b_l}
                                            : {32'b0, a_l} * {32'b0, b_l};
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic wait_idle(input string nm);
    int g = 0;
    while (Busy === 1'b1 && g < 100) begin
      cyc(); #1; g++;
    end
    chk({nm, "_idle_timeout"}, 32'(Busy), 32'd0);
  endtask

  task automatic read_hilo(input string nm);
    cyc(); MfhiE = 1; #1;
    e = exp_q.pop_front();
    chk({nm, "_hi"}, HiLoOutE, e);
    chk({nm, "_hi_stall"}, 32'(StallHL), 32'd0);
    cyc(); MfhiE = 0; MfloE = 1; #1;
    e = exp_q.pop_front();
    chk({nm, "_lo"}, HiLoOutE, e);
    cyc(); MfloE = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    cyc(); cyc(); #1;
    chk("rst_start", 32'(mif.MultStart), 0);
    chk("rst_sgn", 32'(mif.MultStartSgn), 0);
    chk("rst_out", HiLoOutE, 0);
    chk("rst_stall", 32'(StallHL), 0);
    chk("rst_busy", 32'(Busy), 0);
    cyc(); rst = 0;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    read_hilo("rst_regs");
  endtask

  task automatic do_mult(input string nm, input logic sgn, input logic [31:0] a, b,
                         input logic [31:0] eh, el);
    cyc(); MultE = 1; MultSgnE = sgn; op_a = a; op_b = b; #1;
    exp_q.push_back(eh);
    exp_q.push_back(el);
    chk({nm, "_start"}, 32'(mif.MultStart), 1);
    chk({nm, "_startsgn"}, 32'(mif.MultStartSgn), 32'(sgn));
    cyc(); MultE = 0; MultSgnE = 0; #1;
    chk({nm, "_start_pulse"}, 32'(mif.MultStart), 0);
    chk({nm, "_sgn_pulse"}, 32'(mif.MultStartSgn), 0);
    chk({nm, "_busy"}, 32'(Busy), 1);
    wait_idle(nm);
    read_hilo(nm);
  endtask

  task automatic test_mult();
    do_mult("multu", 0, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE);
    do_mult("mult", 1, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
  endtask

  task automatic test_mfhi_stall();
    int stalls = 0;
    cyc(); MultE = 1; op_a = 32'h8000_0000; op_b = 32'd4; #1;
    exp_q.push_back(32'd2);
    cyc(); MultE = 0; MfhiE = 1; #1;
    while (StallHL === 1'b1 && stalls < 60) begin
      stalls++;
      cyc(); #1;
    end
    chk("mfhi_stall_cycles", 32'(stalls), 32'(EXP_STALL));
    e = exp_q.pop_front();
    chk("mfhi_after_stall", HiLoOutE, e);
    cyc(); MfhiE = 0;
    wait_idle("mfhi_stall");
  endtask

  task automatic test_mthi_mtlo();
    cyc(); MthiE = 1; SrcAE = 32'h0000_1234; #1;
    chk("mthi_stall", 32'(StallHL), 0);
    exp_q.push_back(32'h0000_1234);
    exp_q.push_back(32'h0000_ABCD);
    cyc(); MthiE = 0; MtloE = 1; SrcAE = 32'h0000_ABCD; #1;
    chk("mtlo_stall", 32'(StallHL), 0);
    cyc(); MtloE = 0; SrcAE = 0;
    read_hilo("mtx");
    cyc(); MfhiE = 1; MfloE = 1; #1;
    chk("both_rd_hi_prio", HiLoOutE, 32'h0000_1234);
    cyc(); MfhiE = 0; MfloE = 0; MthiE = 1; MtloE = 1; SrcAE = 32'h0000_0055;
    exp_q.push_back(32'h55);
    exp_q.push_back(32'h55);
    cyc(); MthiE = 0; MtloE = 0; SrcAE = 0;
    read_hilo("mt_both");
  endtask

  task automatic test_back_to_back();
    int stalls = 0;
    logic early = 0;
    cyc(); MultE = 1; op_a = 32'd3; op_b = 32'd5; #1;
    cyc(); op_a = 32'h0001_0000; op_b = 32'h0001_0000; #1;
    exp_q.push_back(32'd1);
    exp_q.push_back(32'd0);
    while (StallHL === 1'b1 && stalls < 60) begin
      if (mif.MultStart !== 1'b0) early = 1;
      stalls++;
      cyc(); #1;
    end
    chk("b2b_no_early_start", 32'(early), 0);
    chk("b2b_stall_cycles", 32'(stalls), 32'(MULT_LATENCY));
    chk("b2b_second_start", 32'(mif.MultStart), 1);
    cyc(); MultE = 0;
    wait_idle("b2b");
    read_hilo("b2b");
  endtask

  task automatic test_reset_midflight();
    cyc(); MultE = 1; op_a = 32'd9; op_b = 32'd9; #1;
    cyc(); MultE = 0;
    repeat (8) cyc();
    rst = 1;
    cyc(); rst = 0; #1;
    chk("midrst_busy", 32'(Busy), 0);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd0);
    read_hilo("midrst");
    repeat (30) cyc();
    #1;
    chk("midrst_stale_done_seen", 32'(mif.mult_done), 1);
    chk("midrst_busy_late", 32'(Busy), 0);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd0);
    read_hilo("midrst_late");
  endtask

  initial begin
    test_reset();
    test_mult();
    test_mfhi_stall();
    test_mthi_mtlo();
    test_back_to_back();
    test_reset_midflight();
    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
